jedro_1_run_ctrl: RTL

Synthesizable run controller and result checker for directed instruction tests on jedro_1_top. Reset sequence, cycle budget and register checks are parameters and inputs, so one block serves every instruction test instead of a hand-written bench per test. It sequences DUT reset, runs until illegal-instruction halt or cycle budget, drains the pipeline, then reads back and compares NUM_CHECKS register/value pairs through a regfile debug read port. It sits beside the core in the test top and reports pass/fail plus first-failure diagnostics.

---
 rtl/jedro_1_run_ctrl_pkg.sv | 23 ++
 rtl/jedro_1_run_checker.sv | 100 ++++++++++
 rtl/jedro_1_run_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/jedro_1_run_ctrl_pkg.sv
// Shared types and width helpers for the jedro_1 directed-test run controller.
package jedro_1_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_RUN,
    ST_DRAIN,
    ST_CHECK,
    ST_DONE
  } run_state_e;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Bits needed to index n entries; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/jedro_1_run_checker.sv
// Pipelined register readback: one address per slot, compare one slot later.
module jedro_1_run_checker
  import jedro_1_run_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_CHECKS     = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic                                 clear_i,
  input  logic                                 start_i,
  input  logic                                 stop_i,
  input  logic [NUM_CHECKS-1:0]                chk_en_i,
  input  logic [NUM_CHECKS*REG_ADDR_WIDTH-1:0] chk_addr_i,
  input  logic [NUM_CHECKS*DATA_WIDTH-1:0]     chk_val_i,
  input  logic [DATA_WIDTH-1:0]                rf_rdata_i,
  output logic [REG_ADDR_WIDTH-1:0]            rf_raddr_o,
  output logic                                 done_o,
  output logic [cnt_w(NUM_CHECKS)-1:0]         fail_cnt_o,
  output logic [idx_w(NUM_CHECKS)-1:0]         first_fail_idx_o,
  output logic [DATA_WIDTH-1:0]                first_fail_val_o
);

  localparam int SW = cnt_w(NUM_CHECKS);
  localparam int IW = idx_w(NUM_CHECKS);

  logic                  active_q;
  logic [SW-1:0]         slot_q;
  logic [SW-1:0]         fail_cnt_q;
  logic [IW-1:0]         first_idx_q;
  logic [DATA_WIDTH-1:0] first_val_q;

  logic                  cmp_en;
  logic [DATA_WIDTH-1:0] cmp_exp;
  logic [IW-1:0]         cmp_idx;
  logic                  mismatch;

  // Slot k issues address k and judges entry k-1, whose data has just returned.
  always_comb begin
    rf_raddr_o = '0;
    cmp_en     = 1'b0;
    cmp_exp    = '0;
    cmp_idx    = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      if (active_q && slot_q == SW'(i)) begin
        rf_raddr_o = chk_addr_i[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
      end
      if (active_q && slot_q == SW'(i + 1)) begin
        cmp_en  = chk_en_i[i];
        cmp_exp = chk_val_i[i*DATA_WIDTH +: DATA_WIDTH];
        cmp_idx = IW'(i);
      end
    end
  end

  assign mismatch = cmp_en && (rf_rdata_i != cmp_exp);
  assign done_o   = active_q && (slot_q == SW'(NUM_CHECKS));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      active_q    <= 1'b0;
      slot_q      <= '0;
      fail_cnt_q  <= '0;
      first_idx_q <= '0;
      first_val_q <= '0;
    end else if (clear_i) begin
      active_q    <= 1'b0;
      slot_q      <= '0;
      fail_cnt_q  <= '0;
      first_idx_q <= '0;
      first_val_q <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      slot_q   <= '0;
    end else if (active_q) begin
      if (stop_i) begin
        active_q <= 1'b0;
      end else begin
        if (mismatch) begin
          fail_cnt_q <= fail_cnt_q + 1'b1;
          if (fail_cnt_q == '0) begin
            first_idx_q <= cmp_idx;
            first_val_q <= rf_rdata_i;
          end
        end
        if (done_o) begin
          active_q <= 1'b0;
        end else begin
          slot_q <= slot_q + 1'b1;
        end
      end
    end
  end

  assign fail_cnt_o       = fail_cnt_q;
  assign first_fail_idx_o = first_idx_q;
  assign first_fail_val_o = first_val_q;

endmodule

// File: rtl/jedro_1_run_ctrl.sv
// Run controller for jedro_1 directed tests: reset core, run to halt or budget,
// drain, then read back and judge register values.
module jedro_1_run_ctrl
  import jedro_1_run_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_CHECKS     = 4,
  parameter int RESET_CYCLES   = 3,
  parameter int MAX_CYCLES     = 64,
  parameter int DRAIN_CYCLES   = 3,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic                                 start_i,
  input  logic                                 abort_i,
  input  logic                                 illegal_instr_i,
  input  logic [NUM_CHECKS-1:0]                chk_en_i,
  input  logic [NUM_CHECKS*REG_ADDR_WIDTH-1:0] chk_addr_i,
  input  logic [NUM_CHECKS*DATA_WIDTH-1:0]     chk_val_i,
  output logic [REG_ADDR_WIDTH-1:0]            rf_raddr_o,
  input  logic [DATA_WIDTH-1:0]                rf_rdata_i,
  output logic                                 dut_rstn_o,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 pass_o,
  output logic                                 timeout_o,
  output logic                                 illegal_seen_o,
  output logic [cnt_w(NUM_CHECKS)-1:0]         fail_cnt_o,
  output logic [idx_w(NUM_CHECKS)-1:0]         first_fail_idx_o,
  output logic [DATA_WIDTH-1:0]                first_fail_val_o,
  output logic [CNT_WIDTH-1:0]                 cycle_cnt_o,
  output run_state_e                           state_o
);

  localparam int RSW = cnt_w(RESET_CYCLES);
  localparam int DSW = cnt_w(DRAIN_CYCLES);

  run_state_e           state_q;
  logic [RSW-1:0]       rst_cnt_q;
  logic [DSW-1:0]       drain_cnt_q;
  logic [CNT_WIDTH-1:0] cycle_cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 dut_rstn_q;
  logic                 timeout_q;
  logic                 illegal_q;
  logic                 aborted_q;

  logic start_ok;
  logic abort_run;
  logic chk_start;
  logic chk_done;

  assign start_ok  = start_i && (state_q == ST_IDLE || state_q == ST_DONE);
  assign abort_run = abort_i && (state_q == ST_RESET || state_q == ST_RUN ||
                                 state_q == ST_DRAIN || state_q == ST_CHECK);

  // Checker handshake: chk_start is a one-cycle pulse on the edge that enters
  // CHECK; chk_done is high for exactly the final slot and the FSM leaves CHECK
  // on that same edge. chk_clear wipes results when a new run is accepted.
  assign chk_start = (state_q == ST_DRAIN) && !abort_i &&
                     (drain_cnt_q == DSW'(DRAIN_CYCLES - 1));

  jedro_1_run_checker #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
    .NUM_CHECKS    (NUM_CHECKS)
  ) u_checker (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .clear_i         (start_ok),
    .start_i         (chk_start),
    .stop_i          (abort_run),
    .chk_en_i        (chk_en_i),
    .chk_addr_i      (chk_addr_i),
    .chk_val_i       (chk_val_i),
    .rf_rdata_i      (rf_rdata_i),
    .rf_raddr_o      (rf_raddr_o),
    .done_o          (chk_done),
    .fail_cnt_o      (fail_cnt_o),
    .first_fail_idx_o(first_fail_idx_o),
    .first_fail_val_o(first_fail_val_o)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      rst_cnt_q   <= '0;
      drain_cnt_q <= '0;
      cycle_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dut_rstn_q  <= 1'b0;
      timeout_q   <= 1'b0;
      illegal_q   <= 1'b0;
      aborted_q   <= 1'b0;
    end else if (abort_run) begin
      // Results freeze where they stand; only the status flags move.
      state_q    <= ST_DONE;
      busy_q     <= 1'b0;
      done_q     <= 1'b1;
      dut_rstn_q <= 1'b0;
      aborted_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_q     <= ST_RESET;
            rst_cnt_q   <= '0;
            drain_cnt_q <= '0;
            cycle_cnt_q <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            dut_rstn_q  <= 1'b0;
            timeout_q   <= 1'b0;
            illegal_q   <= 1'b0;
            aborted_q   <= 1'b0;
          end
        end
        ST_RESET: begin
          if (rst_cnt_q == RSW'(RESET_CYCLES - 1)) begin
            state_q    <= ST_RUN;
            dut_rstn_q <= 1'b1;
          end else begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (cycle_cnt_q != CNT_WIDTH'(MAX_CYCLES)) begin
            cycle_cnt_q <= cycle_cnt_q + 1'b1;
          end
          // Illegal takes priority, even on the last budget cycle.
          if (illegal_instr_i) begin
            illegal_q <= 1'b1;
            state_q   <= ST_DRAIN;
          end else if (cycle_cnt_q >= CNT_WIDTH'(MAX_CYCLES - 1)) begin
            timeout_q <= 1'b1;
            state_q   <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (chk_start) begin
            state_q <= ST_CHECK;
          end else begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
          end
        end
        ST_CHECK: begin
          if (chk_done) begin
            state_q    <= ST_DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            dut_rstn_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dut_rstn_o     = dut_rstn_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign timeout_o      = timeout_q;
  assign illegal_seen_o = illegal_q;
  assign cycle_cnt_o    = cycle_cnt_q;
  assign state_o        = state_q;
  assign pass_o         = done_q && !aborted_q && illegal_q && (fail_cnt_o == '0);

endmodule
